ps2_rx_frame: RTL and testbench
===============================

// Module: ps2_rx_frame
// PURPOSE
//  PS/2 device-to-host receiver for the wb_ps2 block, upstream of the scan-code-to-ASCII table.
//  Synchronises and de-glitches ps2_clk/ps2_data, deserialises 11-bit frames and checks odd parity.
//  Folds the E0 (extended) and F0 (break) prefixes into flags and emits one qualified scan code per key event.
// PARAMETERS
//  FILTER_LEN      8      ps2_clk glitch-filter depth, in clk cycles (>=2)
//  TIMEOUT_CYCLES  50000  max clk cycles between falling edges inside a frame (1 ms @ 50 MHz)
// PORTS
//  clk         in   1  system clock; single clock domain
//  reset       in   1  synchronous, active-high reset
//  ps2_clk     in   1  raw PS/2 clock line, asynchronous
//  ps2_data    in   1  raw PS/2 data line, asynchronous
//  rx_en       in   1  receive enable; 0 = ignore line / abort frame
//  scan_code   out  8  last completed non-prefix scan code (held until next valid)
//  scan_valid  out  1  1-cycle pulse: scan_code/is_break/is_ext are new
//  is_break    out  1  F0 preceded this code (key release)
//  is_ext      out  1  E0 preceded this code
//  parity_err  out  1  1-cycle pulse: parity bit wrong
//  frame_err   out  1  1-cycle pulse: bad stop bit or inter-edge timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; bit count, shift reg, timeout ctr, prefix flags = 0; filtered clk = 1.
//  Input path: 2-flop synchroniser on each line. Filtered ps2_clk goes 1 when the last FILTER_LEN
//   synced samples are all 1, goes 0 when all 0, otherwise holds. fall_tick = 1-cycle pulse on the 1->0 transition of filtered clk.
//   ps2_data (synced) is sampled on fall_tick.
//  FSM (advances only on fall_tick unless noted):
//   IDLE:   data=0 and rx_en=1 -> DATA, bitcnt=0; data=1 -> stay (ignore).
//   DATA:   shift right, new bit into [7] (LSB first); after 8th bit -> PARITY.
//   PARITY: ok iff ^{shift,bit}==1; store result -> STOP.
//   STOP:   -> IDLE. stop=0 -> frame_err. stop=1 & parity bad -> parity_err. Both bad -> frame_err only.
//           Either error: clear prefix flags, no scan_valid.
//  Byte handling (good frame): E0 -> ext flag=1, no pulse; F0 -> brk flag=1, no pulse;
//   other -> scan_code=byte, is_break=brk, is_ext=ext, scan_valid=1, then clear both flags.
//  Latency: outputs/pulses registered, asserted the cycle after the stop-bit fall_tick.
//  Timeout: ctr clears on every fall_tick and in IDLE. Outside IDLE, ctr==TIMEOUT_CYCLES-1 ->
//   frame_err pulse, FSM=IDLE, prefix flags cleared, partial byte discarded.
//  rx_en=0: FSM forced to IDLE next cycle, prefix flags cleared, no error pulse; outputs held.
//  Reset mid-frame: IDLE next cycle, partial frame discarded, no pulse.
//  Timeout and stop-bit fall_tick in the same cycle: fall_tick wins (ctr cleared).
//  At most one of scan_valid/parity_err/frame_err per frame.
// TESTING
//  1. Frame 0x1C (start0, 00111000 LSB-first, par0, stop1) -> scan_valid 1 cycle, scan_code=1C, is_break=0, is_ext=0.
//  2. Frames F0,1C -> single scan_valid with code=1C, is_break=1, is_ext=0; no pulse after F0.
//  3. Frames E0,F0,75 -> single scan_valid, code=75, is_ext=1, is_break=1; next 1C has both flags 0.
//  4. 0x1C with par=1 -> parity_err pulse, no scan_valid; F0 then bad frame then 1C -> is_break=0.
//  5. Stall after 4 data bits >TIMEOUT_CYCLES -> frame_err pulse, IDLE; next good 0x45 -> code=45.
//  6. 3-cycle low glitch on idle ps2_clk (FILTER_LEN=8) -> no fall_tick, no state change;
//     stop bit 0 -> frame_err only; reset and rx_en=0 mid-frame -> no pulses, clean next frame.

Source files
------------

// File: rtl/ps2_rx_frame_if.sv
// Line-side and decoded-output signals of the PS/2 receive path.
// master drives the raw lines and enable; slave is the receiver itself.
interface ps2_rx_frame_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rx_en;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_ext;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data, rx_en,
    input  scan_code, scan_valid, is_break, is_ext, parity_err, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, rx_en,
    output scan_code, scan_valid, is_break, is_ext, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: line sync/de-glitch, 11-bit frame deserialiser with odd
// parity, and E0/F0 prefix folding into one qualified scan code per key event.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_rx_frame_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  filt, filt_d;
  logic                  fall_tick, data_s;

  state_t        state_q, state_n;
  logic [2:0]    bitcnt_q, bitcnt_n;
  logic [7:0]    shift_q, shift_n;
  logic          par_ok_q, par_ok_n;
  logic [TW-1:0] tctr_q, tctr_n;
  logic          ext_q, ext_n, brk_q, brk_n;
  logic [7:0]    code_q, code_n;
  logic          valid_q, valid_n, isbrk_q, isbrk_n, isext_q, isext_n;
  logic          perr_q, perr_n, ferr_q, ferr_n;

  assign fall_tick = filt_d & ~filt;
  assign data_s    = data_sync[1];

  // Lines idle high, so the synchronisers and filter come out of reset at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      hist      <= '1;
      filt      <= 1'b1;
      filt_d    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      hist      <= {hist[FILTER_LEN-2:0], clk_sync[1]};
      if (&hist)
        filt <= 1'b1;
      else if (~|hist)
        filt <= 1'b0;
      filt_d    <= filt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b0;
      tctr_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      isbrk_q  <= 1'b0;
      isext_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      bitcnt_q <= bitcnt_n;
      shift_q  <= shift_n;
      par_ok_q <= par_ok_n;
      tctr_q   <= tctr_n;
      ext_q    <= ext_n;
      brk_q    <= brk_n;
      code_q   <= code_n;
      valid_q  <= valid_n;
      isbrk_q  <= isbrk_n;
      isext_q  <= isext_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
    end
  end

  // A stop-bit fall_tick takes priority over a coincident timeout.
  always_comb begin
    state_n  = state_q;
    bitcnt_n = bitcnt_q;
    shift_n  = shift_q;
    par_ok_n = par_ok_q;
    tctr_n   = tctr_q;
    ext_n    = ext_q;
    brk_n    = brk_q;
    code_n   = code_q;
    isbrk_n  = isbrk_q;
    isext_n  = isext_q;
    valid_n  = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;

    if (!bus.rx_en) begin
      state_n = IDLE;
      tctr_n  = '0;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end else if (state_q == IDLE) begin
      tctr_n = '0;
      if (fall_tick && !data_s) begin
        state_n  = DATA;
        bitcnt_n = '0;
      end
    end else if (fall_tick) begin
      tctr_n = '0;
      case (state_q)
        DATA: begin
          shift_n  = {data_s, shift_q[7:1]};
          bitcnt_n = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7)
            state_n = PARITY;
        end
        PARITY: begin
          par_ok_n = ^{shift_q, data_s};
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!data_s || !par_ok_q) begin
            ferr_n = !data_s;
            perr_n = data_s;
            ext_n  = 1'b0;
            brk_n  = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_n = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_n = 1'b1;
          end else begin
            code_n  = shift_q;
            isbrk_n = brk_q;
            isext_n = ext_q;
            valid_n = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (tctr_q == TLAST) begin
      ferr_n  = 1'b1;
      state_n = IDLE;
      tctr_n  = '0;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end else begin
      tctr_n = tctr_q + TW'(1);
    end
  end

  assign bus.scan_code  = code_q;
  assign bus.scan_valid = valid_q;
  assign bus.is_break   = isbrk_q;
  assign bus.is_ext     = isext_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: frame-level reference model fed by directed
// and $urandom frames; DUT pulses are collected into an event queue and compared.
module tb_ps2_rx_frame;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 200;
  localparam int H          = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   fall_cycle = 0;
  int   last_evt_cycle = 0;

  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  bit          m_ext, m_brk;
  logic [7:0]  m_last;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse becomes one event: {kind, is_break, is_ext, scan_code}.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.scan_valid) begin
        obs_q.push_back({2'd1, bus.is_break, bus.is_ext, bus.scan_code});
        last_evt_cycle = cyc;
      end
      if (bus.parity_err) obs_q.push_back({2'd2, 10'd0});
      if (bus.frame_err)  obs_q.push_back({2'd3, 10'd0});
    end
  end

  function automatic void model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    if (!stop_ok || !par_ok) begin
      exp_q.push_back(stop_ok ? {2'd2, 10'd0} : {2'd3, 10'd0});
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back({2'd1, m_brk, m_ext, b});
      m_last = b;
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    idle(H);
    bus.ps2_clk = 1'b0;
    fall_cycle = cyc;
    idle(H);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    bus.ps2_data = 1'b1;
    idle(40);
    model_frame(b, !bad_par, !bad_stop);
  endtask

  task automatic send_partial(input logic [3:0] bits);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    bus.ps2_data = 1'b1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    m_ext = 0;
    m_brk = 0;
    m_last = 8'h00;
  endtask

  task automatic test_reset();
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rx_en = 1'b1;
    reset = 1'b1;
    idle(5);
    reset = 1'b0;
    m_ext = 0;
    m_brk = 0;
    m_last = 8'h00;
    idle(1);
    total++; if (bus.scan_code !== 8'h00) $display("[TB] FAIL reset_scan_code got %h expected 00", bus.scan_code); else passed++;
    total++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL reset_scan_valid got %b expected 0", bus.scan_valid); else passed++;
    total++; if (bus.is_break !== 1'b0) $display("[TB] FAIL reset_is_break got %b expected 0", bus.is_break); else passed++;
    total++; if (bus.is_ext !== 1'b0) $display("[TB] FAIL reset_is_ext got %b expected 0", bus.is_ext); else passed++;
    total++; if ({bus.parity_err, bus.frame_err} !== 2'b00) $display("[TB] FAIL reset_errors got %b expected 00", {bus.parity_err, bus.frame_err}); else passed++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single_code();
    send_frame(8'h1C, 0, 0);
    total++;
    if (last_evt_cycle - fall_cycle < 4 || last_evt_cycle - fall_cycle > FILTER_LEN + 8)
      $display("[TB] FAIL single_latency got %0d cycles expected 4..%0d", last_evt_cycle - fall_cycle, FILTER_LEN + 8);
    else passed++;
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL single_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL single_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_prefixes();
    send_frame(8'hF0, 0, 0);
    total++; if (obs_q.size() !== 0) $display("[TB] FAIL prefix_f0_silent got %0d events expected 0", obs_q.size()); else passed++;
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'h1C, 0, 0);
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL prefix_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL prefix_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    send_frame(8'h1C, 1, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h22, 1, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h33, 0, 1);
    send_frame(8'h33, 1, 1);
    send_frame(8'h33, 0, 0);
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL errors_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL errors_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    send_frame(8'hF0, 0, 0);
    send_partial(4'b1010);
    idle(TIMEOUT + 100);
    exp_q.push_back({2'd3, 10'd0});
    m_ext = 0;
    m_brk = 0;
    send_frame(8'h45, 0, 0);
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL timeout_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL timeout_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    bus.ps2_data = 1'b0;
    bus.ps2_clk = 1'b0;
    idle(3);
    bus.ps2_clk = 1'b1;
    idle(H);
    bus.ps2_data = 1'b1;
    idle(40);
    total++; if (obs_q.size() !== 0) $display("[TB] FAIL glitch_silent got %0d events expected 0", obs_q.size()); else passed++;
    send_frame(8'h5A, 0, 0);
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL glitch_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL glitch_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    send_frame(8'h2A, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_partial(4'b0110);
    bus.rx_en = 1'b0;
    idle(5);
    m_ext = 0;
    m_brk = 0;
    total++; if (bus.scan_code !== m_last) $display("[TB] FAIL abort_held_code got %h expected %h", bus.scan_code, m_last); else passed++;
    bus.rx_en = 1'b1;
    idle(10);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_partial(4'b1001);
    pulse_reset();
    idle(1);
    total++; if (bus.scan_code !== 8'h00) $display("[TB] FAIL abort_reset_code got %h expected 00", bus.scan_code); else passed++;
    idle(10);
    send_frame(8'h1C, 0, 0);
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL abort_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL abort_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int k;
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 5);
      b = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end
    total++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL random_count got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL random_event%0d got %h expected %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_code();
    test_prefixes();
    test_errors();
    test_timeout();
    test_glitch();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
